// File: rtl/div_gen.sv
// div_gen: restoring shift-subtract divider, signed/unsigned, with abort and divide-by-zero.
// Define DIV_GEN_ZERO_FAST_EN to skip the iterations when the divisor is zero.
module div_gen #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST_SYNC,
   input  logic             DIV_REQ_IN,
   input  logic             DIV_SIGNED_IN,
   input  logic             DIV_ABORT_IN,
   input  logic [WIDTH-1:0] DIV_DIVIDEND_IN,
   input  logic [WIDTH-1:0] DIV_DIVISOR_IN,
   output logic             DIV_BUSY_OUT,
   output logic             DIV_ACK_OUT,
   output logic [WIDTH-1:0] DIV_QUOTIENT_OUT,
   output logic [WIDTH-1:0] DIV_REMAINDER_OUT,
   output logic             DIV_DBZ_OUT
);
   localparam int CW = $clog2(WIDTH + 1);
`ifdef DIV_GEN_ZERO_FAST_EN
   localparam bit ZERO_FAST = 1'b1;
`else
   localparam bit ZERO_FAST = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} stateT;
   stateT state, nextState;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] quo, rem, dvs, dvdCap, dvsCap;
   logic [WIDTH:0] shifted, diff;
   logic sgnCap, reqArmed, accept, dvsZero;
   // reqArmed is low after reset, so a request already high must fall before it can start a division
   assign accept = (state == IDLE) && DIV_REQ_IN && reqArmed && !DIV_ABORT_IN;
   assign dvsZero = (dvsCap == '0);
   assign shifted = {rem, quo[WIDTH-1]};
   assign diff = shifted - {1'b0, dvs};
   assign DIV_BUSY_OUT = (state != IDLE);
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: nextState = accept ? LOAD : IDLE;
         LOAD: nextState = DIV_ABORT_IN ? IDLE : (ZERO_FAST && dvsZero) ? DONE : ITER;
         ITER: nextState = DIV_ABORT_IN ? IDLE : (cnt == CW'(1)) ? DONE : ITER;
         DONE: nextState = IDLE;
      endcase
   end
   always_ff @(posedge CLK) state <= RST_SYNC ? IDLE : nextState;
   always_ff @(posedge CLK) begin
      if (RST_SYNC) begin
         reqArmed <= 1'b0;
         cnt <= '0;
         quo <= '0;
         rem <= '0;
         dvs <= '0;
         dvdCap <= '0;
         dvsCap <= '0;
         sgnCap <= 1'b0;
         DIV_ACK_OUT <= 1'b0;
         DIV_QUOTIENT_OUT <= '0;
         DIV_REMAINDER_OUT <= '0;
         DIV_DBZ_OUT <= 1'b0;
      end else begin
         reqArmed <= ~DIV_REQ_IN;
         DIV_ACK_OUT <= 1'b0;
         unique case (state)
            IDLE: if (accept) begin
               dvdCap <= DIV_DIVIDEND_IN;
               dvsCap <= DIV_DIVISOR_IN;
               sgnCap <= DIV_SIGNED_IN;
            end
            LOAD: begin
               quo <= (sgnCap && dvdCap[WIDTH-1]) ? -dvdCap : dvdCap;
               dvs <= (sgnCap && dvsCap[WIDTH-1]) ? -dvsCap : dvsCap;
               rem <= '0;
               cnt <= CW'(WIDTH);
            end
            ITER: begin
               rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
               cnt <= cnt - CW'(1);
            end
            DONE: if (!DIV_ABORT_IN) begin
               DIV_ACK_OUT <= 1'b1;
               DIV_DBZ_OUT <= dvsZero;
               DIV_QUOTIENT_OUT <= dvsZero ? '1 :
                  (sgnCap && (dvdCap[WIDTH-1] ^ dvsCap[WIDTH-1])) ? -quo : quo;
               DIV_REMAINDER_OUT <= dvsZero ? dvdCap : (sgnCap && dvdCap[WIDTH-1]) ? -rem : rem;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div_gen.sv
// tb_div_gen: directed checks of div_gen at WIDTH=32 and WIDTH=8.
module tb_div_gen;
`ifdef DIV_GEN_ZERO_FAST_EN
   localparam int ZLAT = 2;
`else
   localparam int ZLAT = 34;
`endif
   logic CLK = 1'b0;
   logic rst = 1'b1;
   logic req = 1'b0, sgn = 1'b0, abort = 1'b0;
   logic [31:0] dvd = '0, dvs = '0;
   logic busy, ack, dbz;
   logic [31:0] q, r;
   logic req8 = 1'b0, sgn8 = 1'b0, abort8 = 1'b0;
   logic [7:0] dvd8 = '0, dvs8 = '0;
   logic busy8, ack8, dbz8;
   logic [7:0] q8, r8;
   int nChecks = 0, nFail = 0;
   int lat;
   bit busyOk;
   always #5 CLK = ~CLK;
   div_gen #(.WIDTH(32)) dut (
      .CLK(CLK), .RST_SYNC(rst), .DIV_REQ_IN(req), .DIV_SIGNED_IN(sgn), .DIV_ABORT_IN(abort),
      .DIV_DIVIDEND_IN(dvd), .DIV_DIVISOR_IN(dvs), .DIV_BUSY_OUT(busy), .DIV_ACK_OUT(ack),
      .DIV_QUOTIENT_OUT(q), .DIV_REMAINDER_OUT(r), .DIV_DBZ_OUT(dbz));
   div_gen #(.WIDTH(8)) dut8 (
      .CLK(CLK), .RST_SYNC(rst), .DIV_REQ_IN(req8), .DIV_SIGNED_IN(sgn8), .DIV_ABORT_IN(abort8),
      .DIV_DIVIDEND_IN(dvd8), .DIV_DIVISOR_IN(dvs8), .DIV_BUSY_OUT(busy8), .DIV_ACK_OUT(ack8),
      .DIV_QUOTIENT_OUT(q8), .DIV_REMAINDER_OUT(r8), .DIV_DBZ_OUT(dbz8));

   // Start a division and return how many edges after the accepting edge ACK became visible (-1 on timeout)
   task automatic doDiv(input bit sel8, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int latOut, output bit busyGood);
      @(negedge CLK);
      if (sel8) begin sgn8 = s; dvd8 = a[7:0]; dvs8 = b[7:0]; req8 = 1'b1; end
      else begin sgn = s; dvd = a; dvs = b; req = 1'b1; end
      @(posedge CLK); #1;
      if (!hold) begin if (sel8) req8 = 1'b0; else req = 1'b0; end
      busyGood = 1'b1;
      latOut = -1;
      for (int i = 1; i <= 100; i++) begin
         if (!(sel8 ? busy8 : busy)) busyGood = 1'b0;
         @(posedge CLK); #1;
         if (sel8 ? ack8 : ack) begin latOut = i; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      nChecks++; if (ack !== 1'b0) begin nFail++; $display("FAIL reset_ack got=%b exp=0", ack); end
      nChecks++; if (q !== 32'h0 || r !== 32'h0) begin nFail++; $display("FAIL reset_qr got=%h/%h exp=0/0", q, r); end
      nChecks++; if (dbz !== 1'b0) begin nFail++; $display("FAIL reset_dbz got=%b exp=0", dbz); end
      @(negedge CLK); rst = 1'b0;
   endtask

   task automatic test_unsigned();
      doDiv(1'b0, 1'b0, 32'd100, 32'd7, 1'b0, lat, busyOk);
      nChecks++; if (lat != 34) begin nFail++; $display("FAIL unsigned_latency got=%0d exp=34", lat); end
      nChecks++; if (!busyOk) begin nFail++; $display("FAIL unsigned_busy got=0 exp=1 before ack"); end
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL unsigned_busy_at_ack got=%b exp=0", busy); end
      nChecks++; if (q !== 32'd14) begin nFail++; $display("FAIL unsigned_q got=%0d exp=14", q); end
      nChecks++; if (r !== 32'd2) begin nFail++; $display("FAIL unsigned_r got=%0d exp=2", r); end
      nChecks++; if (dbz !== 1'b0) begin nFail++; $display("FAIL unsigned_dbz got=%b exp=0", dbz); end
      @(posedge CLK); #1;
      nChecks++; if (ack !== 1'b0) begin nFail++; $display("FAIL ack_pulse_width got=%b exp=0", ack); end
      nChecks++; if (q !== 32'd14) begin nFail++; $display("FAIL unsigned_hold_q got=%0d exp=14", q); end
   endtask

   task automatic test_signed();
      doDiv(1'b0, 1'b1, 32'hFFFF_FFF9, 32'h2, 1'b0, lat, busyOk);
      nChecks++; if (q !== 32'hFFFF_FFFD) begin nFail++; $display("FAIL signed_q got=%h exp=fffffffd", q); end
      nChecks++; if (r !== 32'hFFFF_FFFF) begin nFail++; $display("FAIL signed_r got=%h exp=ffffffff", r); end
      doDiv(1'b0, 1'b0, 32'hFFFF_FFF9, 32'h2, 1'b0, lat, busyOk);
      nChecks++; if (q !== 32'h7FFF_FFFC) begin nFail++; $display("FAIL unsigned_big_q got=%h exp=7ffffffc", q); end
      nChecks++; if (r !== 32'h1) begin nFail++; $display("FAIL unsigned_big_r got=%h exp=00000001", r); end
   endtask

   task automatic test_overflow();
      doDiv(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, busyOk);
      nChecks++; if (q !== 32'h8000_0000) begin nFail++; $display("FAIL overflow_q got=%h exp=80000000", q); end
      nChecks++; if (r !== 32'h0) begin nFail++; $display("FAIL overflow_r got=%h exp=00000000", r); end
      nChecks++; if (dbz !== 1'b0) begin nFail++; $display("FAIL overflow_dbz got=%b exp=0", dbz); end
   endtask

   task automatic test_dbz();
      for (int s = 0; s < 2; s++) begin
         doDiv(1'b0, s[0], 32'h1234, 32'h0, 1'b0, lat, busyOk);
         nChecks++; if (lat != ZLAT) begin nFail++; $display("FAIL dbz_latency s=%0d got=%0d exp=%0d", s, lat, ZLAT); end
         nChecks++; if (q !== 32'hFFFF_FFFF) begin nFail++; $display("FAIL dbz_q s=%0d got=%h exp=ffffffff", s, q); end
         nChecks++; if (r !== 32'h1234) begin nFail++; $display("FAIL dbz_r s=%0d got=%h exp=00001234", s, r); end
         nChecks++; if (dbz !== 1'b1) begin nFail++; $display("FAIL dbz_flag s=%0d got=%b exp=1", s, dbz); end
      end
      doDiv(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h4, 1'b0, lat, busyOk);
      nChecks++; if (dbz !== 1'b0 || q !== 32'hFFFF_FFFC) begin nFail++; $display("FAIL dbz_clear got=%b/%h exp=0/fffffffc", dbz, q); end
   endtask

   task automatic test_abort_idle();
      @(negedge CLK); dvd = 32'd9; dvs = 32'd3; req = 1'b1; abort = 1'b1;
      @(posedge CLK); #1;
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL abort_wins_idle got=%b exp=0", busy); end
      @(negedge CLK); abort = 1'b0;
      @(posedge CLK); #1;
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL held_req_after_abort got=%b exp=0", busy); end
      @(negedge CLK); req = 1'b0;
   endtask

   task automatic test_held_req();
      int starts = 0;
      doDiv(1'b0, 1'b0, 32'd20, 32'd3, 1'b1, lat, busyOk);
      nChecks++; if (q !== 32'd6 || r !== 32'd2) begin nFail++; $display("FAIL held_result got=%0d/%0d exp=6/2", q, r); end
      for (int i = 0; i < 6; i++) begin @(posedge CLK); #1; if (busy) starts++; end
      nChecks++; if (starts != 0) begin nFail++; $display("FAIL held_req_restart got=%0d busy cycles exp=0", starts); end
      @(negedge CLK); req = 1'b0;
   endtask

   task automatic test_back_to_back();
      lat = -1;
      @(negedge CLK); sgn = 1'b0; dvd = 32'd100; dvs = 32'd7; req = 1'b1;
      @(posedge CLK); #1; req = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge CLK);
         if (i == 4) begin dvd = 32'd50; dvs = 32'd5; req = 1'b1; end
         if (i == 5) req = 1'b0;
         @(posedge CLK); #1;
         if (ack) begin lat = i; break; end
      end
      nChecks++; if (lat != 34) begin nFail++; $display("FAIL ignore_latency got=%0d exp=34", lat); end
      nChecks++; if (q !== 32'd14 || r !== 32'd2) begin nFail++; $display("FAIL ignore_result got=%0d/%0d exp=14/2", q, r); end
      @(posedge CLK); #1;
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL ignore_no_queue got=%b exp=0", busy); end
   endtask

   task automatic test_abort();
      int acks = 0;
      @(negedge CLK); sgn = 1'b0; dvd = 32'd1000; dvs = 32'd10; req = 1'b1;
      @(posedge CLK); #1; req = 1'b0;
      repeat (10) @(posedge CLK);
      @(negedge CLK); abort = 1'b1;
      @(posedge CLK); #1;
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL abort_busy got=%b exp=0", busy); end
      @(negedge CLK); abort = 1'b0;
      for (int i = 0; i < 40; i++) begin @(posedge CLK); #1; if (ack) acks++; end
      nChecks++; if (acks != 0) begin nFail++; $display("FAIL abort_ack got=%0d exp=0", acks); end
      nChecks++; if (q !== 32'd14 || r !== 32'd2) begin nFail++; $display("FAIL abort_hold got=%0d/%0d exp=14/2", q, r); end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      @(negedge CLK); sgn = 1'b0; dvd = 32'd77; dvs = 32'd5; req = 1'b1;
      repeat (15) @(posedge CLK);
      @(negedge CLK); rst = 1'b1;
      @(posedge CLK); #1;
      nChecks++; if (busy !== 1'b0 || ack !== 1'b0 || q !== 32'h0 || r !== 32'h0 || dbz !== 1'b0) begin
         nFail++; $display("FAIL reset_mid got=b%b a%b q%h r%h d%b exp=all zero", busy, ack, q, r, dbz); end
      @(negedge CLK); rst = 1'b0;
      for (int i = 0; i < 50; i++) begin @(posedge CLK); #1; if (ack || busy) bad++; end
      nChecks++; if (bad != 0) begin nFail++; $display("FAIL reset_no_restart got=%0d active cycles exp=0", bad); end
      @(negedge CLK); req = 1'b0;
   endtask

   task automatic test_width8();
      doDiv(1'b1, 1'b0, 32'd200, 32'd3, 1'b0, lat, busyOk);
      nChecks++; if (lat != 10) begin nFail++; $display("FAIL w8_latency got=%0d exp=10", lat); end
      nChecks++; if (q8 !== 8'd66 || r8 !== 8'd2) begin nFail++; $display("FAIL w8_result got=%0d/%0d exp=66/2", q8, r8); end
      nChecks++; if (!busyOk) begin nFail++; $display("FAIL w8_busy got=0 exp=1 before ack"); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_overflow();
      test_dbz();
      test_abort_idle();
      test_held_req();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_width8();
      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
      $finish;
   end
endmodule

// File: doc/div_gen.md
DIV_GEN -- requirements
Module: div_gen

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_SYNC  input  1  reset, synchronous, active-high.
REQ-004 DIV_REQ_IN  input  1  start request; rising edge (sampled vs previous-cycle value) starts a division.
REQ-005 DIV_SIGNED_IN  input  1  1 = two's-complement division, 0 = unsigned; captured with operands.
REQ-006 DIV_ABORT_IN  input  1  cancels an in-flight division.
REQ-007 DIV_DIVIDEND_IN  input  WIDTH  dividend, captured on accept.
REQ-008 DIV_DIVISOR_IN  input  WIDTH  divisor, captured on accept.
REQ-009 DIV_BUSY_OUT  output  1  high whenever state is not IDLE.
REQ-010 DIV_ACK_OUT  output  1  one-cycle result-valid pulse.
REQ-011 DIV_QUOTIENT_OUT  output  WIDTH  registered quotient.
REQ-012 DIV_REMAINDER_OUT  output  WIDTH  registered remainder.
REQ-013 DIV_DBZ_OUT  output  1  registered divide-by-zero flag, updated with ACK.

Function
REQ-014 States SHALL be IDLE, LOAD, ITER, DONE; DIV_BUSY_OUT = (state != IDLE).
REQ-015 Accept: in IDLE, rising edge of DIV_REQ_IN with DIV_ABORT_IN low SHALL capture operands and signed flag, then go to LOAD.
REQ-016 A DIV_REQ_IN rising edge outside IDLE SHALL be ignored, with no queuing.
REQ-017 LOAD SHALL load the core with |dividend| and |divisor|, set the iteration counter to WIDTH, then go to ITER.
- Absolute value is taken only when the signed flag is set and the operand MSB is 1.
REQ-018 ITER SHALL perform one restoring shift-subtract step per cycle and decrement the counter.
- Go to DONE after the WIDTH-th step.
REQ-019 DONE SHALL register quotient, remainder and DBZ, pulse DIV_ACK_OUT high for exactly one cycle, then go to IDLE.
REQ-020 Latency: DIV_ACK_OUT SHALL be high in the cycle following the (WIDTH+2)th rising edge after the accepting edge.
REQ-021 Sign fix (signed only): quotient negated iff dividend MSB XOR divisor MSB; remainder negated iff dividend MSB.
REQ-022 Divide-by-zero: DIV_QUOTIENT_OUT = all ones, DIV_REMAINDER_OUT = captured dividend unmodified, DIV_DBZ_OUT = 1.
- Applies regardless of the signed flag; DIV_DBZ_OUT = 0 otherwise.
REQ-023 Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0, DBZ = 0.
REQ-024 Outputs and DIV_DBZ_OUT SHALL hold their last values until the next DONE.
REQ-025 DIV_ABORT_IN high in LOAD/ITER/DONE SHALL return to IDLE at the next edge.
- No ACK is generated; outputs are unchanged.
REQ-026 DIV_ABORT_IN and a DIV_REQ_IN rising edge together in IDLE: abort wins, request not accepted.
REQ-027 After ACK, a new division SHALL require a fresh DIV_REQ_IN rising edge; a held-high request does not restart.

Reset
REQ-028 RST_SYNC high at a rising edge SHALL force IDLE and clear the counter, core register and captured operands.
- Also clears the edge-detect register, so a request already high is not treated as a rising edge.
REQ-029 Reset SHALL zero all outputs: DIV_BUSY_OUT=0, DIV_ACK_OUT=0, DIV_QUOTIENT_OUT=0, DIV_REMAINDER_OUT=0, DIV_DBZ_OUT=0.
REQ-030 Reset mid-operation SHALL discard the division with no ACK; RST_SYNC has priority over all other inputs.

Configuration
REQ-031 Macro DIV_GEN_ZERO_FAST_EN selects the divide-by-zero path.
- Defined: a zero divisor detected in LOAD SHALL go directly to DONE, so ACK comes after the 2nd edge following accept; results per REQ-022.
- Undefined: zero divisor runs all WIDTH iterations (REQ-020 latency); results identical.

Verification (WIDTH=32 unless stated)
REQ-032 Unsigned 100/7 -> Q=14, R=2, DBZ=0; ACK single-cycle pulse in the cycle after the 34th edge after accept; BUSY high from accept until ACK.
REQ-033 Signed 0xFFFFFFF9/0x00000002 -> Q=0xFFFFFFFD, R=0xFFFFFFFF; same operands unsigned -> Q=0x7FFFFFFC, R=0x00000001.
REQ-034 Signed 0x80000000/0xFFFFFFFF -> Q=0x80000000, R=0, DBZ=0.
REQ-035 0x00001234/0 (signed and unsigned) -> Q=0xFFFFFFFF, R=0x00001234, DBZ=1.
- ACK after 34 edges without DIV_GEN_ZERO_FAST_EN, after 2 edges with it.
REQ-036 Second REQ edge during ITER is ignored, first result correct.
- Abort on the 10th ITER cycle -> BUSY low next cycle, no ACK, outputs keep previous result.
REQ-037 Reset asserted mid-ITER with REQ held high -> all outputs 0, no ACK, no restart after reset.
- WIDTH=8 instance, unsigned 200/3 -> Q=66, R=2; ACK after 10 edges.
